// File: rtl/m_axi_stream.sv
// m_axi_stream: buffered AXI4-Stream master that drains its local buffer as one packet per start pulse
module m_axi_stream #(
    parameter int DWIDTH  = 32,
    parameter int BUFSIZE = 8
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                buf_we,
    input  logic [BUFSIZE-1:0]  buf_addr,
    input  logic [DWIDTH-1:0]   buf_wdata,
    input  logic                start,
    input  logic [BUFSIZE:0]    length,
    input  logic                tready,
    output logic                tvalid,
    output logic [DWIDTH-1:0]   tdata,
    output logic [DWIDTH/8-1:0] tstrb,
    output logic                tlast,
    output logic                busy,
    output logic                done
);
    localparam logic [BUFSIZE:0]   WORDS   = {1'b1, {BUFSIZE{1'b0}}};
    localparam logic [BUFSIZE:0]   REM_ONE = {{BUFSIZE{1'b0}}, 1'b1};
    localparam logic [BUFSIZE-1:0] PTR_ONE = {{(BUFSIZE-1){1'b0}}, 1'b1};
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
    state_t               state_q, state_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DWIDTH-1:0]    tdata_q, tdata_d;
    logic [BUFSIZE-1:0]   read_ptr_q, read_ptr_d;
    logic [BUFSIZE:0]     remain_q, remain_d;
    logic [DWIDTH-1:0]    mem [0:(1<<BUFSIZE)-1];
    logic                 ld;
    always_ff @(posedge clk)
        if (buf_we && !busy_q) mem[buf_addr] <= buf_wdata;
    assign ld = state_q == S_SEND && remain_q != '0 && (!tvalid_q || tready);
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        read_ptr_d = read_ptr_q;
        remain_d   = remain_q;
        case (state_q)
            S_IDLE: if (start) begin
                busy_d     = 1'b1;
                state_d    = length == '0 ? S_DONE : S_SEND;
                read_ptr_d = '0;
                remain_d   = length > WORDS ? WORDS : length;
            end
            S_SEND: begin
                if (ld) begin
                    tdata_d    = mem[read_ptr_q];
                    tvalid_d   = 1'b1;
                    tlast_d    = remain_q == REM_ONE;
                    read_ptr_d = read_ptr_q + PTR_ONE;
                    remain_d   = remain_q - REM_ONE;
                end else if (tvalid_q && tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
                if (tvalid_q && tready && tlast_q) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            read_ptr_q <= '0;
            remain_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            read_ptr_q <= read_ptr_d;
            remain_q   <= remain_d;
        end
    end
    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
    assign tstrb  = '1;
    assign tlast  = tlast_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_m_axi_stream.sv
// tb_m_axi_stream: directed self-checking bench for m_axi_stream with a 16-word buffer
module tb_m_axi_stream;
    localparam int DW = 32;
    localparam int BS = 4;
    logic          clk, xrst, buf_we, start, tready;
    logic [BS-1:0] buf_addr;
    logic [DW-1:0] buf_wdata, tdata;
    logic [BS:0]   length;
    logic [DW/8-1:0] tstrb;
    logic          tvalid, tlast, busy, done;
    int            n_tests = 0, n_fail = 0, done_cnt = 0, cyc_n = 0;
    logic [DW-1:0] q_data[$];
    bit            q_last[$];
    int            q_cyc[$];
    m_axi_stream #(.DWIDTH(DW), .BUFSIZE(BS)) dut (
        .clk(clk), .xrst(xrst), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .start(start), .length(length), .tready(tready),
        .tvalid(tvalid), .tdata(tdata), .tstrb(tstrb), .tlast(tlast),
        .busy(busy), .done(done)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) begin
        if (xrst && tvalid && tready) begin
            q_data.push_back(tdata);
            q_last.push_back(tlast);
            q_cyc.push_back(cyc_n);
        end
        if (done) done_cnt <= done_cnt + 1;
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input int a, input logic [DW-1:0] d);
        buf_we = 1'b1;
        buf_addr = a[BS-1:0];
        buf_wdata = d;
        cyc(1);
        buf_we = 1'b0;
    endtask
    task automatic go(input int len);
        start = 1'b1;
        length = len[BS:0];
        cyc(1);
        start = 1'b0;
    endtask
    task automatic clr();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask
    task automatic wait_done(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask
    function automatic logic [31:0] last_bits();
        logic [31:0] r = '0;
        for (int i = 0; i < q_last.size() && i < 32; i++) r[i] = q_last[i];
        return r;
    endfunction
    initial begin
        int d0;
        logic [DW-1:0] pat [4];
        pat = '{32'h11, 32'h22, 32'h33, 32'h44};
        xrst = 1'b0; buf_we = 1'b0; buf_addr = '0; buf_wdata = '0;
        start = 1'b0; length = '0; tready = 1'b0;
        cyc(2);
        chk("rst tvalid", 64'(tvalid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst tlast", 64'(tlast), 64'd0);
        chk("rst tdata", 64'(tdata), 64'd0);
        chk("tstrb", 64'(tstrb), 64'hF);
        xrst = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) wr(i, pat[i]);
        // straight packet at full throughput
        clr();
        tready = 1'b1;
        d0 = done_cnt;
        go(4);
        chk("t1 busy", 64'(busy), 64'd1);
        chk("t1 no early valid", 64'(tvalid), 64'd0);
        cyc(1);
        chk("t1 first valid", 64'(tvalid), 64'd1);
        chk("t1 first data", 64'(tdata), 64'h11);
        wait_done("t1 done seen", 20);
        chk("t1 busy after done", 64'(busy), 64'd0);
        cyc(3);
        chk("t1 one done pulse", 64'(done_cnt - d0), 64'd1);
        chk("t1 beats", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < q_data.size(); i++) chk("t1 data", 64'(q_data[i]), 64'(pat[i]));
        chk("t1 tlast pattern", 64'(last_bits()), 64'h8);
        if (q_cyc.size() == 4) chk("t1 consecutive", 64'(q_cyc[3] - q_cyc[0]), 64'd3);
        // backpressure then alternating ready
        clr();
        tready = 1'b0;
        go(4);
        cyc(1);
        chk("t2 valid", 64'(tvalid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("t2 stall valid", 64'(tvalid), 64'd1);
            chk("t2 stall data", 64'(tdata), 64'h11);
            chk("t2 stall last", 64'(tlast), 64'd0);
        end
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 30; i++) begin
                tready = (i % 2) == 0;
                cyc(1);
                if (done) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("t2 done seen", 64'(ok), 64'd1);
        end
        tready = 1'b1;
        chk("t2 beats", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < q_data.size(); i++) chk("t2 data", 64'(q_data[i]), 64'(pat[i]));
        chk("t2 tlast pattern", 64'(last_bits()), 64'h8);
        // zero-length packet
        cyc(2);
        clr();
        d0 = done_cnt;
        go(0);
        chk("t3 busy", 64'(busy), 64'd1);
        chk("t3 no valid", 64'(tvalid), 64'd0);
        cyc(1);
        chk("t3 done", 64'(done), 64'd1);
        chk("t3 busy low", 64'(busy), 64'd0);
        cyc(1);
        chk("t3 done pulse end", 64'(done), 64'd0);
        chk("t3 one done", 64'(done_cnt - d0), 64'd1);
        chk("t3 no beats", 64'(q_data.size()), 64'd0);
        // full depth and clipped length
        for (int i = 0; i < 16; i++) wr(i, DW'(i));
        for (int t = 0; t < 2; t++) begin
            clr();
            go(t == 0 ? 16 : 31);
            wait_done("t4 done seen", 40);
            chk("t4 beats", 64'(q_data.size()), 64'd16);
            for (int i = 0; i < q_data.size(); i++) chk("t4 data", 64'(q_data[i]), 64'(i));
            chk("t4 tlast pattern", 64'(last_bits()), 64'h8000);
            cyc(2);
        end
        // write while busy is dropped
        go(3);
        wr(2, 32'hFF);
        wait_done("t5a done seen", 20);
        cyc(2);
        clr();
        go(3);
        wait_done("t5b done seen", 20);
        chk("t5 beats", 64'(q_data.size()), 64'd3);
        if (q_data.size() == 3) chk("t5 mem2 kept", 64'(q_data[2]), 64'd2);
        // reset mid-packet
        cyc(2);
        for (int i = 0; i < 4; i++) wr(i, pat[i]);
        clr();
        d0 = done_cnt;
        go(4);
        cyc(3);
        chk("t6 beats before rst", 64'(q_data.size()), 64'd2);
        #2 xrst = 1'b0;
        #1;
        chk("t6 rst tvalid", 64'(tvalid), 64'd0);
        chk("t6 rst busy", 64'(busy), 64'd0);
        chk("t6 rst tlast", 64'(tlast), 64'd0);
        cyc(2);
        xrst = 1'b1;
        cyc(3);
        chk("t6 no done", 64'(done_cnt - d0), 64'd0);
        clr();
        go(4);
        wait_done("t6 done seen", 20);
        chk("t6 beats", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < q_data.size(); i++) chk("t6 data", 64'(q_data[i]), 64'(pat[i]));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
